turn_sequencer: RTL and testbench
=================================

# turn_sequencer

Sequences a single player turn between the game FSM's turn grant (next_turn with dog_turn/cat_turn) and its turn_done_dog/turn_done_cat inputs. Per turn it:
- arms the fire input and charges shot power while fire is held;
- hands a launch request to the projectile engine over a valid/ready handshake and waits for impact;
- applies damage to the target's HP register, enforces a turn timeout, then pulses turn_done.

It owns hp_dog and hp_cat, which feed the FSM's hp_local/hp_remote inputs.

## Interface
- POWER_MAX, 100: charge saturation value; power is 7 bits.
- CHARGE_DIV, 500000: clock cycles per +1 power step; ≥1.
- TURN_TIMEOUT, 500000000: clock cycles allowed in WAIT_PRESS plus CHARGE; ≥2.
- HP_INIT, 100: HP load value; 10 bits.
- DMG_HIT, 10: damage on hit.
- DMG_CRIT, 25: damage on critical hit.

- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start_game  in  1  level from game FSM; a rising edge reloads both HP registers
- next_turn  in  1  level: a turn is in progress
- dog_turn  in  1  dog's turn
- cat_turn  in  1  cat's turn
- fire_local  in  1  dog fire button, level, already synchronised
- fire_remote  in  1  cat fire button, level, already synchronised
- launch_valid  out  1  launch request
- launch_ready  in  1  projectile engine accepts the request
- launch_power  out  7  power, stable while launch_valid=1
- launch_dir  out  1  0 = dog throws at cat, 1 = cat throws at dog
- impact_valid  in  1  one-cycle pulse: the projectile has landed
- impact_hit  in  1  hit flag, qualified by impact_valid
- impact_crit  in  1  crit flag, qualified by impact_valid; only meaningful with impact_hit
- hp_dog  out  10  dog HP
- hp_cat  out  10  cat HP
- turn_done_dog  out  1  one-cycle pulse: dog turn finished
- turn_done_cat  out  1  one-cycle pulse: cat turn finished
- charge_level  out  7  current power, for the HUD
- seq_state  out  3  state encoding, for debug/HUD

## Operation
States are IDLE, WAIT_PRESS, CHARGE, LAUNCH, FLIGHT, APPLY, DONE.

- **IDLE**
  - Exit condition: next_turn=1 and (dog_turn|cat_turn) → WAIT_PRESS.
  - On exit, latch the active side: dog if dog_turn=1 (dog wins if both are set), otherwise cat.
  - On exit, clear power, the timeout counter and the armed flag.
- **WAIT_PRESS**
  - fire is the active side's button.
  - armed sets when fire=0 is sampled; a press carried over from the previous turn is therefore ignored.
  - armed=1 and fire=1 → CHARGE.
- **CHARGE**
  - Power increments by 1 every CHARGE_DIV cycles and saturates at POWER_MAX.
  - fire=0 → LAUNCH.
- **LAUNCH**
  - launch_valid=1, launch_power = latched power, launch_dir = active side.
  - When launch_valid and launch_ready are both 1 in a cycle → FLIGHT.
- **FLIGHT**: wait for impact_valid, then → APPLY with hit/crit captured.
- **APPLY**
  - Damage = DMG_CRIT if crit&hit, DMG_HIT if hit only, 0 on a miss.
  - The target (the opposite side) is decremented with saturation at 0, never wrapping.
  - → DONE.
- **DONE**
  - Pulse turn_done for the active side for exactly one cycle.
  - Then wait for next_turn=0 and go to IDLE.
- **Timeout**
  - The counter runs in WAIT_PRESS and CHARGE.
  - On reaching TURN_TIMEOUT in WAIT_PRESS → DONE with no launch and no damage.
  - On reaching TURN_TIMEOUT in CHARGE → LAUNCH with the current power.
- **Abort**
  - next_turn=0 in any state other than IDLE or DONE → IDLE next cycle.
  - launch_valid drops on abort.
  - HP is not changed by an aborted turn.
  - An impact_valid arriving after the abort is ignored.
- **start_game rising edge**: HP reload takes priority over an APPLY in the same cycle.

## Timing
- Reset values:
  - state IDLE, launch_valid 0, launch_power 0, launch_dir 0;
  - hp_dog = hp_cat = HP_INIT;
  - turn_done_dog = turn_done_cat = 0;
  - charge_level 0, seq_state 0.
- All outputs are registered; each state transition takes effect on the clock edge after its condition is sampled.
- Release of fire in CHARGE → launch_valid=1 on the next cycle.
- The launch handshake completes in the cycle where launch_valid and launch_ready are both 1.
- impact_valid → HP updated 2 cycles later (FLIGHT→APPLY, then APPLY→DONE).
- turn_done is asserted in the same cycle as the HP update, so the game FSM sees the new HP in the same cycle as turn_done.

## Structure
- Shared package game_pkg holds:
  - seq_state_t enum;
  - side encoding constants (SIDE_DOG=0, SIDE_CAT=1);
  - widths HP_W=10 and PWR_W=7.
- One sub-module, turn_timer, with ports clk, rst_n, clear, run, expired. It is a TURN_TIMEOUT down-counter.
- The CHARGE_DIV prescaler lives inline in turn_sequencer.

## Test plan
Directed tests run with CHARGE_DIV=2, POWER_MAX=7, TURN_TIMEOUT=40, HP_INIT=100, DMG_HIT=10, DMG_CRIT=25.
- **Dog hit**: dog_turn+next_turn, fire_local 0 then held 6 cycles, then released; launch_ready=1; impact_valid with hit=1 → launch_power=3, launch_dir=0, hp_cat=90, one turn_done_dog pulse, hp_dog stays 100.
- **Cat crit, saturation, backpressure**:
  - Stimulus: cat turn with hp_dog preset to 20 via prior hits; hold fire_remote 30 cycles; launch_ready held 0 for 5 cycles; then crit.
  - Response: power=7; launch_valid held stable for those 5 cycles; hp_dog=0, no wrap.
- **Carried-over press**: fire_local already 1 when next_turn rises → stays in WAIT_PRESS until fire_local falls and rises again.
- **Timeout**:
  - No press: turn_done pulse at ≤42 cycles, no launch_valid.
  - Held press: launch at timeout with the current power.
- **Abort mid-FLIGHT**: next_turn=0, then a later impact_valid hit → HP unchanged, state IDLE, no turn_done.
- **Reset and reload**: rst_n low mid-CHARGE → all outputs return to reset values asynchronously; start_game rising edge → hp_dog = hp_cat = 100.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and widths for the turn sequencer.
// Side encoding, HP/power widths and the sequencer state enum.
package game_pkg;

    localparam int HP_W  = 10;
    localparam int PWR_W = 7;

    localparam logic SIDE_DOG = 1'b0;
    localparam logic SIDE_CAT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_CHARGE = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_FLIGHT = 3'd4,
        ST_APPLY  = 3'd5,
        ST_DONE   = 3'd6
    } seq_state_t;

    // HP never wraps below zero
    function automatic logic [HP_W-1:0] hp_sub(
        input logic [HP_W-1:0] hp,
        input logic [HP_W-1:0] dmg
    );
        return (hp > dmg) ? hp - dmg : '0;
    endfunction

endpackage

// File: rtl/turn_sequencer_if.sv
// Launch handshake between the turn sequencer and the projectile engine.
// The sequencer is the master; the engine answers with launch_ready.
interface turn_sequencer_if;
    import game_pkg::*;

    logic             launch_valid;
    logic             launch_ready;
    logic [PWR_W-1:0] launch_power;
    logic             launch_dir;

    modport master (
        output launch_valid,
        output launch_power,
        output launch_dir,
        input  launch_ready
    );

    modport slave (
        input  launch_valid,
        input  launch_power,
        input  launch_dir,
        output launch_ready
    );

endinterface

// File: rtl/turn_timer.sv
// Turn timeout down-counter: expired rises after TURN_TIMEOUT run cycles.
// clear reloads the counter; it holds at zero until cleared.
module turn_timer #(
    parameter int TURN_TIMEOUT = 500000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TURN_TIMEOUT);
    localparam logic [CW-1:0] LOAD = CW'(TURN_TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= LOAD;
        end else if (clear) begin
            cnt <= LOAD;
        end else if (run && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = run && (cnt == '0);

endmodule

// File: rtl/turn_sequencer.sv
// Sequences one player turn: arm, charge, launch, flight, damage, done.
// Owns both HP registers consumed by the game FSM.
module turn_sequencer
    import game_pkg::*;
#(
    parameter int POWER_MAX    = 100,
    parameter int CHARGE_DIV   = 500000,
    parameter int TURN_TIMEOUT = 500000000,
    parameter int HP_INIT      = 100,
    parameter int DMG_HIT      = 10,
    parameter int DMG_CRIT     = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_game,
    input  logic              next_turn,
    input  logic              dog_turn,
    input  logic              cat_turn,
    input  logic              fire_local,
    input  logic              fire_remote,
    turn_sequencer_if.master  launch,
    input  logic              impact_valid,
    input  logic              impact_hit,
    input  logic              impact_crit,
    output logic [HP_W-1:0]   hp_dog,
    output logic [HP_W-1:0]   hp_cat,
    output logic              turn_done_dog,
    output logic              turn_done_cat,
    output logic [PWR_W-1:0]  charge_level,
    output logic [2:0]        seq_state
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_WAIT   = ST_WAIT;
    localparam logic [2:0] S_CHARGE = ST_CHARGE;
    localparam logic [2:0] S_LAUNCH = ST_LAUNCH;
    localparam logic [2:0] S_FLIGHT = ST_FLIGHT;
    localparam logic [2:0] S_APPLY  = ST_APPLY;
    localparam logic [2:0] S_DONE   = ST_DONE;

    localparam int DW = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
    localparam logic [DW-1:0]    DIV_LAST = DW'(CHARGE_DIV - 1);
    localparam logic [PWR_W-1:0] PMAX     = PWR_W'(POWER_MAX);
    localparam logic [HP_W-1:0]  HP_LOAD  = HP_W'(HP_INIT);
    localparam logic [HP_W-1:0]  D_HIT    = HP_W'(DMG_HIT);
    localparam logic [HP_W-1:0]  D_CRIT   = HP_W'(DMG_CRIT);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             side;
    logic             armed;
    logic             fire;
    logic [DW-1:0]    div_cnt;
    logic             tick;
    logic [PWR_W-1:0] pwr;
    logic [PWR_W-1:0] pwr_nxt;
    logic             hit_q;
    logic             crit_q;
    logic             sg_q;
    logic             sg_rise;
    logic             expired;
    logic             enter_wait;
    logic             apply;
    logic [HP_W-1:0]  dmg;
    logic [HP_W-1:0]  tgt_new;

    turn_timer #(
        .TURN_TIMEOUT(TURN_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == S_IDLE),
        .run     ((state == S_WAIT) || (state == S_CHARGE)),
        .expired (expired)
    );

    assign fire    = (side == SIDE_DOG) ? fire_local : fire_remote;
    assign tick    = (state == S_CHARGE) && (div_cnt == DIV_LAST);
    assign sg_rise = start_game && !sg_q;

    always_comb begin
        pwr_nxt = pwr;
        if (tick && pwr < PMAX) begin
            pwr_nxt = pwr + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (next_turn && (dog_turn || cat_turn)) state_nxt = S_WAIT;
            S_WAIT:   if (expired) state_nxt = S_DONE;
                      else if (armed && fire) state_nxt = S_CHARGE;
            S_CHARGE: if (expired || !fire) state_nxt = S_LAUNCH;
            S_LAUNCH: if (launch.launch_ready) state_nxt = S_FLIGHT;
            S_FLIGHT: if (impact_valid) state_nxt = S_APPLY;
            S_APPLY:  state_nxt = S_DONE;
            S_DONE:   if (!next_turn) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        // turn withdrawn by the game FSM before completion
        if (!next_turn && state != S_IDLE && state != S_DONE) begin
            state_nxt = S_IDLE;
        end
    end

    assign enter_wait = (state == S_IDLE) && (state_nxt == S_WAIT);
    assign apply      = (state == S_APPLY) && (state_nxt == S_DONE);

    always_comb begin
        dmg = '0;
        if (hit_q) begin
            dmg = crit_q ? D_CRIT : D_HIT;
        end
        tgt_new = hp_sub((side == SIDE_DOG) ? hp_cat : hp_dog, dmg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            side    <= SIDE_DOG;
            armed   <= 1'b0;
            div_cnt <= '0;
            pwr     <= '0;
        end else begin
            state <= state_nxt;
            if (enter_wait) begin
                side    <= dog_turn ? SIDE_DOG : SIDE_CAT;
                armed   <= 1'b0;
                div_cnt <= '0;
                pwr     <= '0;
            end else begin
                if (state == S_WAIT && !fire) armed <= 1'b1;
                if (state == S_CHARGE) begin
                    div_cnt <= tick ? '0 : div_cnt + 1'b1;
                    pwr     <= pwr_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q  <= 1'b0;
            crit_q <= 1'b0;
        end else if (state == S_FLIGHT && impact_valid) begin
            hit_q  <= impact_hit;
            crit_q <= impact_crit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            launch.launch_valid <= 1'b0;
            launch.launch_power <= '0;
            launch.launch_dir   <= 1'b0;
            turn_done_dog       <= 1'b0;
            turn_done_cat       <= 1'b0;
        end else begin
            launch.launch_valid <= (state_nxt == S_LAUNCH);
            if (state != S_LAUNCH && state_nxt == S_LAUNCH) begin
                launch.launch_power <= pwr_nxt;
                launch.launch_dir   <= side;
            end
            turn_done_dog <= (state != S_DONE) && (state_nxt == S_DONE)
                             && (side == SIDE_DOG);
            turn_done_cat <= (state != S_DONE) && (state_nxt == S_DONE)
                             && (side == SIDE_CAT);
        end
    end

    // a new game reload wins over damage landing in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sg_q   <= 1'b0;
            hp_dog <= HP_LOAD;
            hp_cat <= HP_LOAD;
        end else begin
            sg_q <= start_game;
            if (sg_rise) begin
                hp_dog <= HP_LOAD;
                hp_cat <= HP_LOAD;
            end else if (apply) begin
                if (side == SIDE_DOG) hp_cat <= tgt_new;
                else                  hp_dog <= tgt_new;
            end
        end
    end

    assign charge_level = pwr;
    assign seq_state    = state;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: table of full turns plus
// hand sequences for carried press, timeouts, abort, reset and reload.
module tb_turn_sequencer;
    import game_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_game = 1'b0;
    logic next_turn = 1'b0;
    logic dog_turn = 1'b0;
    logic cat_turn = 1'b0;
    logic fire_local = 1'b0;
    logic fire_remote = 1'b0;
    logic impact_valid = 1'b0;
    logic impact_hit = 1'b0;
    logic impact_crit = 1'b0;
    logic [HP_W-1:0]  hp_dog;
    logic [HP_W-1:0]  hp_cat;
    logic             turn_done_dog;
    logic             turn_done_cat;
    logic [PWR_W-1:0] charge_level;
    logic [2:0]       seq_state;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    turn_sequencer_if lif ();

    turn_sequencer #(
        .POWER_MAX(7), .CHARGE_DIV(2), .TURN_TIMEOUT(40),
        .HP_INIT(100), .DMG_HIT(10), .DMG_CRIT(25)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_game(start_game),
        .next_turn(next_turn), .dog_turn(dog_turn), .cat_turn(cat_turn),
        .fire_local(fire_local), .fire_remote(fire_remote),
        .launch(lif),
        .impact_valid(impact_valid), .impact_hit(impact_hit),
        .impact_crit(impact_crit),
        .hp_dog(hp_dog), .hp_cat(hp_cat),
        .turn_done_dog(turn_done_dog), .turn_done_cat(turn_done_cat),
        .charge_level(charge_level), .seq_state(seq_state)
    );

    // side: 0 dog, 1 cat, 2 both asserted (dog expected)
    typedef struct {
        int side;
        int press;
        int rdy;
        bit hit;
        bit crit;
        int pwr;
        int dog;
        int cat;
    } vec_t;

    vec_t tv[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_fire(input int side, input logic v);
        if (side == 1) fire_remote = v;
        else           fire_local  = v;
    endtask

    task automatic run_turn(input int i);
        vec_t v;
        int bad;
        v = tv[i];
        dog_turn = (v.side != 1);
        cat_turn = (v.side != 0);
        next_turn = 1'b1;
        fire_local = 1'b0;
        fire_remote = 1'b0;
        step();
        step();
        for (int k = 0; k < v.press; k++) begin
            set_fire(v.side, 1'b1);
            step();
        end
        set_fire(v.side, 1'b0);
        step();
        chk($sformatf("t%0d_lv", i), lif.launch_valid, 1);
        chk($sformatf("t%0d_pwr", i), lif.launch_power, v.pwr);
        chk($sformatf("t%0d_dir", i), lif.launch_dir, (v.side == 1) ? 1 : 0);
        bad = 0;
        for (int k = 0; k < v.rdy; k++) begin
            step();
            if (lif.launch_valid !== 1'b1 || lif.launch_power != v.pwr) bad++;
        end
        chk($sformatf("t%0d_hold", i), bad, 0);
        lif.launch_ready = 1'b1;
        step();
        lif.launch_ready = 1'b0;
        chk($sformatf("t%0d_lv_drop", i), lif.launch_valid, 0);
        chk($sformatf("t%0d_flight", i), seq_state, 4);
        step();
        impact_valid = 1'b1;
        impact_hit = v.hit;
        impact_crit = v.crit;
        step();
        impact_valid = 1'b0;
        impact_hit = 1'b0;
        impact_crit = 1'b0;
        step();
        chk($sformatf("t%0d_done", i),
            (v.side == 1) ? turn_done_cat : turn_done_dog, 1);
        chk($sformatf("t%0d_done_other", i),
            (v.side == 1) ? turn_done_dog : turn_done_cat, 0);
        chk($sformatf("t%0d_hp_dog", i), hp_dog, v.dog);
        chk($sformatf("t%0d_hp_cat", i), hp_cat, v.cat);
        step();
        chk($sformatf("t%0d_pulse_end", i), turn_done_dog | turn_done_cat, 0);
        next_turn = 1'b0;
        dog_turn = 1'b0;
        cat_turn = 1'b0;
        step();
        chk($sformatf("t%0d_idle", i), seq_state, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_state"}, seq_state, 0);
        chk({tag, "_lv"}, lif.launch_valid, 0);
        chk({tag, "_lpwr"}, lif.launch_power, 0);
        chk({tag, "_ldir"}, lif.launch_dir, 0);
        chk({tag, "_hpd"}, hp_dog, 100);
        chk({tag, "_hpc"}, hp_cat, 100);
        chk({tag, "_done"}, turn_done_dog | turn_done_cat, 0);
        chk({tag, "_lvl"}, charge_level, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int got;
        int seen;
        lif.launch_ready = 1'b0;

        tv[0]  = '{0,  6, 0, 1, 0, 3, 100, 90};
        tv[1]  = '{1,  2, 1, 1, 0, 1,  90, 90};
        tv[2]  = '{1,  4, 0, 0, 0, 2,  90, 90};
        tv[3]  = '{1,  5, 2, 1, 0, 2,  80, 90};
        tv[4]  = '{0,  3, 0, 1, 1, 1,  80, 65};
        tv[5]  = '{1,  1, 0, 0, 1, 0,  80, 65};
        tv[6]  = '{1,  8, 0, 1, 0, 4,  70, 65};
        tv[7]  = '{1, 10, 0, 1, 0, 5,  60, 65};
        tv[8]  = '{1, 12, 0, 1, 0, 6,  50, 65};
        tv[9]  = '{1, 14, 0, 1, 0, 7,  40, 65};
        tv[10] = '{1, 16, 0, 1, 0, 7,  30, 65};
        tv[11] = '{1,  6, 0, 1, 0, 3,  20, 65};
        tv[12] = '{1, 30, 5, 1, 1, 7,   0, 65};
        tv[13] = '{2,  2, 0, 1, 0, 1,   0, 55};

        repeat (3) step();
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) run_turn(i);

        // press carried over from before the turn
        fire_local = 1'b1;
        dog_turn = 1'b1;
        next_turn = 1'b1;
        repeat (4) step();
        chk("carry_wait", seq_state, 1);
        fire_local = 1'b0;
        step();
        chk("carry_still_wait", seq_state, 1);
        fire_local = 1'b1;
        step();
        chk("carry_charge", seq_state, 2);
        fire_local = 1'b0;
        step();
        chk("carry_launch", lif.launch_valid, 1);
        next_turn = 1'b0;
        dog_turn = 1'b0;
        step();
        chk("abort_lv_drop", lif.launch_valid, 0);
        chk("abort_idle", seq_state, 0);

        // timeout without a press
        dog_turn = 1'b1;
        next_turn = 1'b1;
        n = 0;
        got = 0;
        seen = 0;
        for (int k = 1; k <= 60 && got == 0; k++) begin
            step();
            if (lif.launch_valid) seen = 1;
            if (turn_done_dog) begin
                got = 1;
                n = k;
            end
        end
        chk("to_done_seen", got, 1);
        chk("to_latency_ok", (n >= 40 && n <= 42) ? 1 : 0, 1);
        chk("to_no_launch", seen, 0);
        chk("to_hp_cat", hp_cat, 55);
        next_turn = 1'b0;
        dog_turn = 1'b0;
        step();

        // timeout while charging forces the launch
        cat_turn = 1'b1;
        next_turn = 1'b1;
        step();
        step();
        fire_remote = 1'b1;
        got = 0;
        for (int k = 0; k < 60 && got == 0; k++) begin
            step();
            if (lif.launch_valid) got = 1;
        end
        chk("toc_launch", got, 1);
        chk("toc_pwr", lif.launch_power, 7);
        chk("toc_dir", lif.launch_dir, 1);
        lif.launch_ready = 1'b1;
        step();
        lif.launch_ready = 1'b0;
        chk("toc_flight", seq_state, 4);

        // abort mid-flight, late impact must be ignored
        next_turn = 1'b0;
        cat_turn = 1'b0;
        fire_remote = 1'b0;
        step();
        chk("abf_idle", seq_state, 0);
        impact_valid = 1'b1;
        impact_hit = 1'b1;
        step();
        impact_valid = 1'b0;
        impact_hit = 1'b0;
        seen = 0;
        repeat (4) begin
            step();
            if (turn_done_dog || turn_done_cat) seen = 1;
        end
        chk("abf_no_done", seen, 0);
        chk("abf_hp_dog", hp_dog, 0);
        chk("abf_hp_cat", hp_cat, 55);
        chk("abf_state", seq_state, 0);

        // new game reload
        start_game = 1'b1;
        step();
        chk("reload_hpd", hp_dog, 100);
        chk("reload_hpc", hp_cat, 100);
        start_game = 1'b0;
        step();

        run_turn(0);

        // asynchronous reset mid-charge
        dog_turn = 1'b1;
        next_turn = 1'b1;
        step();
        step();
        fire_local = 1'b1;
        repeat (6) step();
        chk("pre_rst_charge", seq_state, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        fire_local = 1'b0;
        next_turn = 1'b0;
        dog_turn = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_idle", seq_state, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
